xgmii_tx_scheduler: RTL and testbench
=====================================

# xgmii_tx_scheduler

Two-source transmit scheduler in front of the 64-bit XGMII TX datapath. Arbitrates round-robin between two frame streams at frame boundaries and wraps each granted frame in start/preamble/SFD and terminate. Enforces a minimum inter-frame gap of idle words. On a mid-frame source underrun it emits an XGMII error word and discards the rest of that frame.

## Interface
Parameters:
- MIN_IFG_WORDS, default 2: number of full idle words emitted after the word carrying /T/. Legal range is 1..15.
- UNDERRUN_CNT_W, default 16: width of the underrun counter.

Ports (clock and reset first):
- clk_xgmii_tx  in  1: XGMII TX clock. This is the only clock.
- reset_xgmii_tx  in  1: asynchronous, active-high reset.
- s0_data  in  64: source 0 frame word. Byte lane 0 is bits [7:0] and is sent first.
- s0_valid  in  1: source 0 word valid. In IDLE this also acts as the request.
- s0_last  in  1: final word of the frame.
- s0_bytes  in  3: valid bytes in the last word, packed from lane 0. 0 means 8. Ignored when s0_last is 0.
- s0_ready  out  1: source 0 word accepted this cycle.
- s1_data, s1_valid, s1_last, s1_bytes, s1_ready: same as source 0, for source 1.
- xgmii_txd  out  64: registered XGMII data.
- xgmii_txc  out  8: registered XGMII control, one bit per lane.
- busy  out  1: high whenever state is not IDLE.
- active_src  out  1: source currently granted. Holds its value in IDLE.
- underrun_count  out  UNDERRUN_CNT_W: saturating count of underruns.

## Operation
State machine states: IDLE, DATA, TERM, DROP, IFG.

IDLE:
- Outputs the idle word: txd = 0x0707070707070707, txc = 0xFF.
- Both ready outputs are 0.
- If any sN_valid is high, grant one source. When both request, the source not granted last wins.
- Next cycle: output the preamble word txd = 0xD5555555555555FB, txc = 0x01, and go to DATA.

DATA:
- sN_ready = 1 for the granted source only. The other ready stays 0.
- valid high and last low: pass the word through with txc = 0x00.
- valid high, last high, bytes = k (1..7):
  - lanes 0..k-1 carry data;
  - lane k carries 0xFD;
  - lanes above k carry 0x07;
  - txc = ~((1<<k)-1) & 0xFF;
  - go to IFG.
- valid high, last high, bytes = 0 (8 bytes): pass all data with txc = 0x00 and go to TERM.
- valid low (underrun):
  - output 0xFEFEFEFEFEFEFEFE with txc = 0xFF;
  - increment underrun_count, saturating at all-ones;
  - go to DROP.

TERM:
- Output 0x07070707070707FD with txc = 0xFF, then go to IFG.

DROP:
- Granted sN_ready = 1. Accepted words are discarded.
- Output the idle word.
- Go to IFG on the first valid && last. A frame is never restarted.

IFG:
- Output the idle word for MIN_IFG_WORDS cycles, using a 4-bit down-counter, then go to IDLE.
- Requests seen during IFG are held. Arbitration happens only in IDLE.

Round-robin pointer: updated at grant time. Reset gives priority to source 0.

## Timing
- All XGMII outputs are registered. A word accepted at edge N appears on xgmii_txd/txc after edge N+1.
- sN_ready is combinational from state and grant only. It never depends on sN_valid.
- Request in IDLE at edge N: preamble appears after edge N+1, and the first data word is accepted at edge N+1.
- A frame of W words with a partial last word:
  - 1 preamble word + W data words + MIN_IFG_WORDS idle words;
  - plus 1 arbitration idle word before the next preamble.
- A full last word adds one extra TERM word.
- Reset values: xgmii_txd = 0x0707070707070707, xgmii_txc = 0xFF, both ready outputs 0, busy 0, active_src 0, underrun_count 0, state IDLE, pointer favouring source 0.
- Reset asserted mid-frame: the next cycle output is idle. The partial frame is abandoned with no /T/ and no /E/.
- Simultaneous requests in IDLE: alternate on every grant. A single requester is granted back-to-back, separated only by the IFG.
- A source dropping valid in IDLE before grant is legal. The request is withdrawn.
- underrun_count holds at saturation.

## Structure
- Package xgmii_pkg holds:
  - control byte constants: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE;
  - preamble word constant;
  - idle and error word constants;
  - state enum.
- Sub-module xgmii_rr_arbiter: 2-way round-robin arbiter with request, grant-enable, grant index and last-grant pointer.
- The termination lane mux (bytes -> txd/txc) is a function in xgmii_pkg.

## Test plan
- Single frame: s0 sends 2 words, last bytes = 3.
  - Output: preamble; word0 with txc 0x00; word1 lanes 0-2 data, lane 3 = 0xFD, lanes 4-7 = 0x07, txc 0xF8.
  - Then exactly 2 idle words before IDLE.
- Full last word: s1 sends 1 word with bytes = 0.
  - Output: preamble; data with txc 0x00; 0x07070707070707FD with txc 0xFF; then 2 idle words.
- Contention: both sources hold frames continuously.
  - Grants go s0, s1, s0, s1.
  - Each preamble follows the previous /T/ word by 3 idle words (2 IFG + 1 arbitration).
- Underrun: s0 drops valid for one cycle after its first word of a 4-word frame.
  - Output: 0xFEFEFEFEFEFEFEFE, txc 0xFF.
  - Remaining words are consumed with ready high, then IFG.
  - underrun_count goes 0 -> 1.
- Reset mid-frame: assert reset_xgmii_tx during DATA.
  - Same cycle: outputs are the idle word and txc 0xFF.
  - Ready outputs, busy and underrun_count are 0.
  - After release, the next request from s1 is granted only after s0's pending request, because priority favours s0.
- Saturation: with UNDERRUN_CNT_W = 2, force 5 underruns. underrun_count reads 3 and holds.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII TX constants, scheduler state type and termination lane mux.
package xgmii_pkg;

    localparam logic [7:0] CTL_IDLE  = 8'h07;
    localparam logic [7:0] CTL_START = 8'hFB;
    localparam logic [7:0] CTL_TERM  = 8'hFD;
    localparam logic [7:0] CTL_ERROR = 8'hFE;

    localparam logic [63:0] PREAMBLE_WORD = {56'hD5555555555555, CTL_START};
    localparam logic [63:0] IDLE_WORD     = {8{CTL_IDLE}};
    localparam logic [63:0] ERROR_WORD    = {8{CTL_ERROR}};
    localparam logic [63:0] TERM_WORD     = {{7{CTL_IDLE}}, CTL_TERM};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_TERM,
        ST_DROP,
        ST_IFG
    } state_t;

    // Partial last word: data below lane k, /T/ at lane k, idle above.
    function automatic logic [71:0] term_lanes(input logic [63:0] data,
                                               input logic [2:0]  bytes);
        logic [63:0] d;
        logic [7:0]  c;
        d = IDLE_WORD;
        c = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(bytes)) begin
                d[8*i +: 8] = data[8*i +: 8];
                c[i]        = 1'b0;
            end else if (i == int'(bytes)) begin
                d[8*i +: 8] = CTL_TERM;
            end
        end
        return {c, d};
    endfunction

endpackage

// File: rtl/xgmii_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last granted source.
module xgmii_rr_arbiter
    import xgmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_idx
);

    logic last_grant;

    always_comb begin
        if (req == 2'b11) grant_idx = ~last_grant;
        else              grant_idx = req[1] & ~req[0];
    end

    // Reset marks source 1 as last granted so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    last_grant <= 1'b1;
        else if (grant_en && |req)  last_grant <= grant_idx;
    end

endmodule

// File: rtl/xgmii_tx_scheduler.sv
// Two-source XGMII TX scheduler: round-robin framing, IFG and underrun handling.
module xgmii_tx_scheduler
    import xgmii_pkg::*;
#(
    parameter int MIN_IFG_WORDS  = 2,
    parameter int UNDERRUN_CNT_W = 16
) (
    input  logic                      clk_xgmii_tx,
    input  logic                      reset_xgmii_tx,
    input  logic [63:0]               s0_data,
    input  logic                      s0_valid,
    input  logic                      s0_last,
    input  logic [2:0]                s0_bytes,
    output logic                      s0_ready,
    input  logic [63:0]               s1_data,
    input  logic                      s1_valid,
    input  logic                      s1_last,
    input  logic [2:0]                s1_bytes,
    output logic                      s1_ready,
    output logic [63:0]               xgmii_txd,
    output logic [7:0]                xgmii_txc,
    output logic                      busy,
    output logic                      active_src,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

    localparam logic [3:0] IFG_LOAD = 4'(MIN_IFG_WORDS);

    state_t      state;
    logic [3:0]  ifg_cnt;
    logic [63:0] nxt_txd;
    logic [7:0]  nxt_txc;
    logic        grant_idx;
    logic        accepting;
    logic [63:0] sel_data;
    logic        sel_valid;
    logic        sel_last;
    logic [2:0]  sel_bytes;

    xgmii_rr_arbiter u_arb (
        .clk       (clk_xgmii_tx),
        .rst       (reset_xgmii_tx),
        .req       ({s1_valid, s0_valid}),
        .grant_en  (state == ST_IDLE),
        .grant_idx (grant_idx)
    );

    assign accepting = (state == ST_DATA) || (state == ST_DROP);
    assign s0_ready  = accepting && !active_src;
    assign s1_ready  = accepting &&  active_src;
    assign busy      = (state != ST_IDLE);

    assign sel_data  = active_src ? s1_data  : s0_data;
    assign sel_valid = active_src ? s1_valid : s0_valid;
    assign sel_last  = active_src ? s1_last  : s0_last;
    assign sel_bytes = active_src ? s1_bytes : s0_bytes;

    // nxt_* holds the word built this edge; it reaches the pins one edge later,
    // which lets the preamble go out while the first data word is accepted.
    always_ff @(posedge clk_xgmii_tx or posedge reset_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            state          <= ST_IDLE;
            active_src     <= 1'b0;
            ifg_cnt        <= 4'd0;
            nxt_txd        <= IDLE_WORD;
            nxt_txc        <= 8'hFF;
            xgmii_txd      <= IDLE_WORD;
            xgmii_txc      <= 8'hFF;
            underrun_count <= '0;
        end else begin
            xgmii_txd <= nxt_txd;
            xgmii_txc <= nxt_txc;
            unique case (state)
                ST_IDLE: begin
                    if (s0_valid || s1_valid) begin
                        active_src <= grant_idx;
                        nxt_txd    <= PREAMBLE_WORD;
                        nxt_txc    <= 8'h01;
                        state      <= ST_DATA;
                    end else begin
                        nxt_txd <= IDLE_WORD;
                        nxt_txc <= 8'hFF;
                    end
                end
                ST_DATA: begin
                    if (!sel_valid) begin
                        nxt_txd <= ERROR_WORD;
                        nxt_txc <= 8'hFF;
                        state   <= ST_DROP;
                        if (underrun_count != '1)
                            underrun_count <= underrun_count + 1'b1;
                    end else if (!sel_last || sel_bytes == 3'd0) begin
                        nxt_txd <= sel_data;
                        nxt_txc <= 8'h00;
                        if (sel_last) state <= ST_TERM;
                    end else begin
                        {nxt_txc, nxt_txd} <= term_lanes(sel_data, sel_bytes);
                        ifg_cnt <= IFG_LOAD;
                        state   <= ST_IFG;
                    end
                end
                ST_TERM: begin
                    nxt_txd <= TERM_WORD;
                    nxt_txc <= 8'hFF;
                    ifg_cnt <= IFG_LOAD;
                    state   <= ST_IFG;
                end
                ST_DROP: begin
                    nxt_txd <= IDLE_WORD;
                    nxt_txc <= 8'hFF;
                    if (sel_valid && sel_last) begin
                        ifg_cnt <= IFG_LOAD;
                        state   <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    // One extra pass here is the arbitration idle before IDLE.
                    nxt_txd <= IDLE_WORD;
                    nxt_txc <= 8'hFF;
                    if (ifg_cnt == 4'd0) state <= ST_IDLE;
                    else                 ifg_cnt <= ifg_cnt - 4'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgmii_tx_scheduler.sv
// Bench for xgmii_tx_scheduler: table-driven frames, scoreboard of output words.
module tb_xgmii_tx_scheduler;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] TERM_W = 64'h07070707070707FD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s0_data, s1_data;
    logic        s0_valid, s0_last, s0_ready;
    logic        s1_valid, s1_last, s1_ready;
    logic [2:0]  s0_bytes, s1_bytes;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        busy, active_src;
    logic [15:0] uc;

    logic [63:0] t_data, t_txd;
    logic        t_valid, t_last, t_ready, t1_ready, t_busy, t_act;
    logic [2:0]  t_bytes;
    logic [7:0]  t_txc;
    logic [1:0]  t_uc;
    logic [63:0] z_data;
    logic        z_valid, z_last;
    logic [2:0]  z_bytes;

    xgmii_tx_scheduler u_dut (
        .clk_xgmii_tx   (clk),
        .reset_xgmii_tx (rst),
        .s0_data        (s0_data),
        .s0_valid       (s0_valid),
        .s0_last        (s0_last),
        .s0_bytes       (s0_bytes),
        .s0_ready       (s0_ready),
        .s1_data        (s1_data),
        .s1_valid       (s1_valid),
        .s1_last        (s1_last),
        .s1_bytes       (s1_bytes),
        .s1_ready       (s1_ready),
        .xgmii_txd      (txd),
        .xgmii_txc      (txc),
        .busy           (busy),
        .active_src     (active_src),
        .underrun_count (uc)
    );

    xgmii_tx_scheduler #(.UNDERRUN_CNT_W(2)) u_sat (
        .clk_xgmii_tx   (clk),
        .reset_xgmii_tx (rst),
        .s0_data        (t_data),
        .s0_valid       (t_valid),
        .s0_last        (t_last),
        .s0_bytes       (t_bytes),
        .s0_ready       (t_ready),
        .s1_data        (z_data),
        .s1_valid       (z_valid),
        .s1_last        (z_last),
        .s1_bytes       (z_bytes),
        .s1_ready       (t1_ready),
        .xgmii_txd      (t_txd),
        .xgmii_txc      (t_txc),
        .busy           (t_busy),
        .active_src     (t_act),
        .underrun_count (t_uc)
    );

    typedef logic [71:0] word_t;
    typedef struct {
        int         src;
        int         nw;
        int         nb;
        logic [7:0] txc_last;
    } vec_t;

    int    tests = 0;
    int    fails = 0;
    word_t cap[$];
    word_t exp_q[$];
    vec_t  tbl[8];

    always @(negedge clk) cap.push_back({txc, txd});

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input word_t got, input word_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] dword(input logic [7:0] tag, input int w);
        logic [7:0] wb;
        wb = w[7:0];
        return {tag, wb, 8'h5A, 8'hC3, ~tag, 8'h99, 8'h3C, tag ^ wb};
    endfunction

    function automatic word_t term_exp(input logic [63:0] d, input int nb,
                                       input logic [7:0] c);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            if (i < nb)       r[8*i +: 8] = d[8*i +: 8];
            else if (i == nb) r[8*i +: 8] = 8'hFD;
            else              r[8*i +: 8] = 8'h07;
        end
        return {c, r};
    endfunction

    task automatic push_frame(input logic [7:0] tag, input int nw, input int nb,
                              input logic [7:0] c);
        exp_q.push_back({8'h01, PRE_W});
        for (int w = 0; w < nw - 1; w++) exp_q.push_back({8'h00, dword(tag, w)});
        if (nb == 0) begin
            exp_q.push_back({8'h00, dword(tag, nw - 1)});
            exp_q.push_back({8'hFF, TERM_W});
        end else begin
            exp_q.push_back(term_exp(dword(tag, nw - 1), nb, c));
        end
        repeat (3) exp_q.push_back({8'hFF, IDLE_W});
    endtask

    task automatic check_stream(input string nm);
        int s;
        s = 0;
        while (s < cap.size() && cap[s] == {8'hFF, IDLE_W}) s++;
        foreach (exp_q[i]) begin
            if (s + i < cap.size()) begin
                chk(nm, cap[s + i], exp_q[i]);
            end else begin
                tests++;
                fails++;
                $display("FAIL %s word %0d missing exp=%h", nm, i, exp_q[i]);
            end
        end
        exp_q.delete();
    endtask

    task automatic wait_rdy(input int which);
        int k;
        k = 0;
        while (k < 300 && !((which == 0) ? s0_ready :
                            (which == 1) ? s1_ready : t_ready)) begin
            @(negedge clk);
            k++;
        end
        if (k == 300) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout src=%0d got=0 exp=1", which);
        end
    endtask

    task automatic settle(input logic which_sat);
        int k;
        k = 0;
        while (k < 300 && (which_sat ? t_busy : busy)) begin
            @(negedge clk);
            k++;
        end
        if (k == 300) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout got=1 exp=0");
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic drive(input int src, input logic [63:0] d, input logic v,
                         input logic l, input logic [2:0] b);
        if (src == 0) begin
            s0_data = d; s0_valid = v; s0_last = l; s0_bytes = b;
        end else begin
            s1_data = d; s1_valid = v; s1_last = l; s1_bytes = b;
        end
    endtask

    task automatic send(input int src, input logic [7:0] tag, input int nw,
                        input int nb, input int gap_at);
        for (int w = 0; w < nw; w++) begin
            if (w == gap_at) begin
                drive(src, 64'h0, 1'b0, 1'b0, 3'd0);
                @(negedge clk);
            end
            drive(src, dword(tag, w), 1'b1, w == nw - 1, 3'(nb));
            wait_rdy(src);
            @(negedge clk);
        end
        drive(src, 64'h0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        tbl[0] = '{0, 2, 3, 8'hF8};
        tbl[1] = '{1, 1, 0, 8'h00};
        tbl[2] = '{0, 1, 1, 8'hFE};
        tbl[3] = '{1, 3, 2, 8'hFC};
        tbl[4] = '{0, 1, 4, 8'hF0};
        tbl[5] = '{1, 2, 5, 8'hE0};
        tbl[6] = '{0, 1, 6, 8'hC0};
        tbl[7] = '{1, 1, 7, 8'h80};

        rst = 1'b1;
        drive(0, 64'h0, 1'b0, 1'b0, 3'd0);
        drive(1, 64'h0, 1'b0, 1'b0, 3'd0);
        t_data = 64'h0; t_valid = 1'b0; t_last = 1'b0; t_bytes = 3'd0;
        z_data = 64'h0; z_valid = 1'b0; z_last = 1'b0; z_bytes = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_txd", {8'h0, txd}, {8'h0, IDLE_W});
        chk("rst_txc", {64'h0, txc}, {64'h0, 8'hFF});
        chk("rst_ready", {70'h0, s1_ready, s0_ready}, 72'h0);
        chk("rst_busy", {71'h0, busy}, 72'h0);
        chk("rst_src", {71'h0, active_src}, 72'h0);
        chk("rst_uc", {56'h0, uc}, 72'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_txd", {txc, txd}, {8'hFF, IDLE_W});

        foreach (tbl[i]) begin
            cap.delete();
            push_frame(8'h10 + 8'(i), tbl[i].nw, tbl[i].nb, tbl[i].txc_last);
            send(tbl[i].src, 8'h10 + 8'(i), tbl[i].nw, tbl[i].nb, -1);
            settle(1'b0);
            check_stream($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_src", i), {71'h0, active_src},
                {71'h0, tbl[i].src[0]});
        end

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cap.delete();
        push_frame(8'hA0, 2, 5, 8'hE0);
        push_frame(8'hB0, 2, 5, 8'hE0);
        push_frame(8'hA1, 2, 5, 8'hE0);
        push_frame(8'hB1, 2, 5, 8'hE0);
        fork
            begin
                send(0, 8'hA0, 2, 5, -1);
                send(0, 8'hA1, 2, 5, -1);
            end
            begin
                send(1, 8'hB0, 2, 5, -1);
                send(1, 8'hB1, 2, 5, -1);
            end
        join
        settle(1'b0);
        check_stream("contention");

        chk("uc_before", {56'h0, uc}, 72'h0);
        cap.delete();
        exp_q.push_back({8'h01, PRE_W});
        exp_q.push_back({8'h00, dword(8'hC0, 0)});
        exp_q.push_back({8'hFF, ERR_W});
        repeat (3) exp_q.push_back({8'hFF, IDLE_W});
        send(0, 8'hC0, 4, 3, 1);
        settle(1'b0);
        check_stream("underrun");
        chk("uc_after", {56'h0, uc}, 72'h1);

        drive(0, dword(8'hD9, 0), 1'b1, 1'b0, 3'd0);
        wait_rdy(0);
        @(negedge clk);
        drive(0, dword(8'hD9, 1), 1'b1, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_word", {txc, txd}, {8'hFF, IDLE_W});
        chk("mid_rst_ready", {70'h0, s1_ready, s0_ready}, 72'h0);
        chk("mid_rst_busy", {71'h0, busy}, 72'h0);
        chk("mid_rst_uc", {56'h0, uc}, 72'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 64'h0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        cap.delete();
        push_frame(8'hD0, 1, 2, 8'hFC);
        push_frame(8'hE0, 1, 2, 8'hFC);
        fork
            send(0, 8'hD0, 1, 2, -1);
            send(1, 8'hE0, 1, 2, -1);
        join
        settle(1'b0);
        check_stream("post_reset_prio");

        for (int i = 1; i <= 5; i++) begin
            t_data = 64'h1111; t_valid = 1'b1; t_last = 1'b0; t_bytes = 3'd1;
            wait_rdy(2);
            @(negedge clk);
            t_valid = 1'b0;
            @(negedge clk);
            t_valid = 1'b1; t_last = 1'b1;
            wait_rdy(2);
            @(negedge clk);
            t_valid = 1'b0; t_last = 1'b0;
            settle(1'b1);
            chk($sformatf("sat_uc%0d", i), {70'h0, t_uc},
                {70'h0, (i < 3) ? 2'(i) : 2'd3});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
